// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the 32-bit CPU datapath.
// The master side is the sequencer; the slave side is the datapath and memory.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        mem_ready;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        PCout;
    logic        MARin;
    logic        IncPC;
    logic        IRin;
    logic        MDRin;
    logic        MDRread;
    logic        MDRout;
    logic        Yin;
    logic        Zin;
    logic        Zlowout;
    logic        Zhighout;
    logic        HIin;
    logic        HIout;
    logic        LOin;
    logic        LOout;
    logic        Cout;
    logic [3:0]  ALUselect;
    logic        mem_read;
    logic        mem_write;
    logic        halted;
    logic        illegal;

    modport master (
        input  ir, mem_ready,
        output reg_in, reg_out, PCout, MARin, IncPC, IRin, MDRin, MDRread, MDRout,
               Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout,
               ALUselect, mem_read, mem_write, halted, illegal
    );

    modport slave (
        output ir, mem_ready,
        input  reg_in, reg_out, PCout, MARin, IncPC, IRin, MDRin, MDRread, MDRout,
               Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout,
               ALUselect, mem_read, mem_write, halted, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch/decode/execute step counter whose outputs are a
// combinational decode of (state, ir), with ready-handshaked memory steps.
module control_sequencer (
    input  logic                       clock,
    input  logic                       clear,
    control_sequencer_if.master        bus
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_WAIT, S_HALT
    } state_t;

    typedef enum logic [4:0] {
        OP_LD   = 5'b00000, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
        OP_ROL, OP_SHR, OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV,
        OP_NEG, OP_NOT,
        OP_MFHI = 5'b11000, OP_MFLO, OP_NOP, OP_HALT
    } opcode_e;

    state_t      state, state_nx;
    logic        illegal_q;
    logic [4:0]  op;
    logic [15:0] sel_ra, sel_rb, sel_rc;
    logic        is_alu, is_imm, is_mem, is_muldiv, is_unary, is_move, is_legal;
    logic [3:0]  alu_code;

    assign op     = bus.ir[31:27];
    assign sel_ra = 16'd1 << bus.ir[26:23];
    assign sel_rb = 16'd1 << bus.ir[22:19];
    assign sel_rc = 16'd1 << bus.ir[18:15];

    assign is_alu    = (op >= OP_ADD) && (op <= OP_SHL);
    assign is_imm    = op inside {OP_ADDI, OP_ANDI, OP_ORI};
    assign is_mem    = op inside {OP_LD, OP_LDI, OP_ST};
    assign is_muldiv = op inside {OP_MUL, OP_DIV};
    assign is_unary  = op inside {OP_NEG, OP_NOT};
    assign is_move   = op inside {OP_MFHI, OP_MFLO};
    assign is_legal  = is_alu || is_imm || is_mem || is_muldiv || is_unary || is_move
                       || (op == OP_NOP) || (op == OP_HALT);

    // Register ALU opcodes are laid out in the same order as the ALU op codes.
    always_comb begin
        alu_code = 4'd0;
        if (is_alu)              alu_code = 4'(op - OP_ADD);
        else if (op == OP_ANDI)  alu_code = 4'd2;
        else if (op == OP_ORI)   alu_code = 4'd3;
        else if (op == OP_MUL)   alu_code = 4'd9;
        else if (op == OP_DIV)   alu_code = 4'd10;
        else if (op == OP_NEG)   alu_code = 4'd11;
        else if (op == OP_NOT)   alu_code = 4'd12;
    end

    always_ff @(posedge clock or negedge clear) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!clear) begin
            state     <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_T2 && !is_legal)
                illegal_q <= 1'b1;
        end
    end

    assign bus.illegal = illegal_q;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_nx      = state;
        bus.reg_in    = '0;
        bus.reg_out   = '0;
        bus.PCout     = 1'b0;
        bus.MARin     = 1'b0;
        bus.IncPC     = 1'b0;
        bus.IRin      = 1'b0;
        bus.MDRin     = 1'b0;
        bus.MDRread   = 1'b0;
        bus.MDRout    = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zin       = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.Zhighout  = 1'b0;
        bus.HIin      = 1'b0;
        bus.HIout     = 1'b0;
        bus.LOin      = 1'b0;
        bus.LOout     = 1'b0;
        bus.Cout      = 1'b0;
        bus.ALUselect = 4'd0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.halted    = 1'b0;

        case (state)
            S_RST: state_nx = S_T0;
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                state_nx  = S_T1;
            end
            S_T1: begin
                bus.mem_read = 1'b1;
                bus.MDRread  = 1'b1;
                bus.MDRin    = bus.mem_ready;
                if (bus.mem_ready) state_nx = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                if (op == OP_NOP)                     state_nx = S_T0;
                else if (op == OP_HALT || !is_legal)  state_nx = S_HALT;
                else                                  state_nx = S_T3;
            end
            S_T3: begin
                state_nx = S_T4;
                if (is_move) begin
                    bus.reg_in = sel_ra;
                    bus.HIout  = (op == OP_MFHI);
                    bus.LOout  = (op == OP_MFLO);
                    state_nx   = S_T0;
                end else if (is_unary) begin
                    bus.reg_out   = sel_rb;
                    bus.ALUselect = alu_code;
                    bus.Zin       = 1'b1;
                end else begin
                    bus.reg_out = is_muldiv ? sel_ra : sel_rb;
                    bus.Yin     = 1'b1;
                end
            end
            S_T4: begin
                state_nx = S_T5;
                if (is_unary) begin
                    bus.Zlowout = 1'b1;
                    bus.reg_in  = sel_ra;
                    state_nx    = S_T0;
                end else begin
                    // Immediate and address forms take the second operand from C.
                    bus.ALUselect = alu_code;
                    bus.Zin       = 1'b1;
                    if (is_muldiv)    bus.reg_out = sel_rb;
                    else if (is_alu)  bus.reg_out = sel_rc;
                    else              bus.Cout    = 1'b1;
                end
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                state_nx    = S_T0;
                if (is_muldiv) begin
                    bus.LOin = 1'b1;
                    state_nx = S_T6;
                end else if (op == OP_LD || op == OP_ST) begin
                    bus.MARin = 1'b1;
                    state_nx  = S_T6;
                end else begin
                    bus.reg_in = sel_ra;
                end
            end
            S_T6: begin
                state_nx = S_T0;
                if (op == OP_LD) begin
                    bus.mem_read = 1'b1;
                    bus.MDRread  = 1'b1;
                    bus.MDRin    = bus.mem_ready;
                    state_nx     = bus.mem_ready ? S_T7 : S_T6;
                end else if (op == OP_ST) begin
                    bus.reg_out = sel_ra;
                    bus.MDRin   = 1'b1;
                    state_nx    = S_T7;
                end else begin
                    bus.Zhighout = 1'b1;
                    bus.HIin     = 1'b1;
                end
            end
            S_T7: begin
                state_nx = S_T0;
                if (op == OP_ST) begin
                    bus.mem_write = 1'b1;
                    if (!bus.mem_ready) state_nx = S_T7;
                end else begin
                    bus.MDRout = 1'b1;
                    bus.reg_in = sel_ra;
                end
            end
            S_HALT: bus.halted = 1'b1;
            // Wait cycles are absorbed by holding T1/T6/T7; WAIT and unused
            // encodings recover to a fresh fetch.
            default: state_nx = S_T0;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed cycle-by-cycle bench for control_sequencer: each step compares the
// full control word against hand-derived values for that step.
module tb_control_sequencer;

    localparam logic [19:0] PCOUT = 20'h80000, MARIN = 20'h40000, INCPC = 20'h20000,
                            IRIN  = 20'h10000, MDRIN = 20'h08000, MDRRD = 20'h04000,
                            MDROUT = 20'h02000, YIN = 20'h01000, ZIN = 20'h00800,
                            ZLOW  = 20'h00400, ZHIGH = 20'h00200, HIIN = 20'h00100,
                            HIOUT = 20'h00080, LOIN = 20'h00040, LOOUT = 20'h00020,
                            COUT  = 20'h00010, MRD = 20'h00008, MWR = 20'h00004,
                            HALTD = 20'h00002, ILL = 20'h00001;
    localparam logic [19:0] T0C = PCOUT | MARIN | INCPC;

    logic clock;
    logic clear;
    int   n_tests = 0;
    int   n_fail  = 0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [18:0] imm);
        return {op, ra, rb, imm};
    endfunction

    function automatic logic [63:0] pack();
        return {8'd0, bus.PCout, bus.MARin, bus.IncPC, bus.IRin, bus.MDRin, bus.MDRread,
                bus.MDRout, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout, bus.HIin,
                bus.HIout, bus.LOin, bus.LOout, bus.Cout, bus.mem_read, bus.mem_write,
                bus.halted, bus.illegal, bus.reg_in, bus.reg_out, bus.ALUselect};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic now_chk(input string tag, input logic [19:0] ctl, input logic [15:0] rin,
                           input logic [15:0] rout, input logic [3:0] alu);
        check(tag, pack(), {8'd0, ctl, rin, rout, alu});
    endtask

    task automatic step_chk(input string tag, input logic [19:0] ctl, input logic [15:0] rin,
                            input logic [15:0] rout, input logic [3:0] alu);
        @(posedge clock);
        @(negedge clock);
        now_chk(tag, ctl, rin, rout, alu);
    endtask

    // Zero-wait fetch from a sampled T0: checks T1 and T2.
    task automatic fetch(input string tag);
        step_chk({tag, "_t1"}, MRD | MDRRD | MDRIN, 16'h0, 16'h0, 4'd0);
        step_chk({tag, "_t2"}, MDROUT | IRIN, 16'h0, 16'h0, 4'd0);
    endtask

    // Asynchronous reset, released just after an edge so RST lasts one full cycle.
    task automatic do_reset(input string tag);
        #2 clear = 1'b0;
        #1 now_chk({tag, "_async"}, 20'h0, 16'h0, 16'h0, 4'd0);
        @(posedge clock);
        #1 clear = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clock);
        now_chk({tag, "_rst"}, 20'h0, 16'h0, 16'h0, 4'd0);
        step_chk({tag, "_t0"}, T0C, 16'h0, 16'h0, 4'd0);
    endtask

    initial begin
        clear         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.ir        = mk_ir(5'd3, 4'd3, 4'd1, {4'd2, 15'd0});
        #1 clear = 1'b0;
        @(negedge clock);
        now_chk("reset", 20'h0, 16'h0, 16'h0, 4'd0);
        clear = 1'b1;

        // add R3,R1,R2
        step_chk("add_t0", T0C, 16'h0, 16'h0, 4'd0);
        fetch("add");
        step_chk("add_t3", YIN, 16'h0, 16'h0002, 4'd0);
        step_chk("add_t4", ZIN, 16'h0, 16'h0004, 4'd0);
        step_chk("add_t5", ZLOW, 16'h0008, 16'h0, 4'd0);
        step_chk("add_end", T0C, 16'h0, 16'h0, 4'd0);

        // sub R2,R7,R9 with three fetch wait cycles
        bus.ir        = mk_ir(5'd4, 4'd2, 4'd7, {4'd9, 15'd0});
        bus.mem_ready = 1'b0;
        step_chk("wait_t1a", MRD | MDRRD, 16'h0, 16'h0, 4'd0);
        step_chk("wait_t1b", MRD | MDRRD, 16'h0, 16'h0, 4'd0);
        step_chk("wait_t1c", MRD | MDRRD, 16'h0, 16'h0, 4'd0);
        bus.mem_ready = 1'b1;
        #1 now_chk("wait_t1d", MRD | MDRRD | MDRIN, 16'h0, 16'h0, 4'd0);
        step_chk("wait_t2", MDROUT | IRIN, 16'h0, 16'h0, 4'd0);
        step_chk("sub_t3", YIN, 16'h0, 16'h0080, 4'd0);
        step_chk("sub_t4", ZIN, 16'h0, 16'h0200, 4'd1);
        step_chk("sub_t5", ZLOW, 16'h0004, 16'h0, 4'd0);
        step_chk("sub_end", T0C, 16'h0, 16'h0, 4'd0);

        // st R4,0x55(R2) with two write wait cycles; mem_ready low in T6 is ignored
        bus.ir = mk_ir(5'd2, 4'd4, 4'd2, 19'h55);
        fetch("st");
        step_chk("st_t3", YIN, 16'h0, 16'h0004, 4'd0);
        step_chk("st_t4", COUT | ZIN, 16'h0, 16'h0, 4'd0);
        step_chk("st_t5", ZLOW | MARIN, 16'h0, 16'h0, 4'd0);
        bus.mem_ready = 1'b0;
        step_chk("st_t6", MDRIN, 16'h0, 16'h0010, 4'd0);
        step_chk("st_t7a", MWR, 16'h0, 16'h0, 4'd0);
        step_chk("st_t7b", MWR, 16'h0, 16'h0, 4'd0);
        bus.mem_ready = 1'b1;
        #1 now_chk("st_t7c", MWR, 16'h0, 16'h0, 4'd0);
        step_chk("st_end", T0C, 16'h0, 16'h0, 4'd0);

        // mul R5,R6
        bus.ir = mk_ir(5'd15, 4'd5, 4'd6, 19'h0);
        fetch("mul");
        step_chk("mul_t3", YIN, 16'h0, 16'h0020, 4'd0);
        step_chk("mul_t4", ZIN, 16'h0, 16'h0040, 4'd9);
        step_chk("mul_t5", ZLOW | LOIN, 16'h0, 16'h0, 4'd0);
        step_chk("mul_t6", ZHIGH | HIIN, 16'h0, 16'h0, 4'd0);
        step_chk("mul_end", T0C, 16'h0, 16'h0, 4'd0);

        // neg R1,R2
        bus.ir = mk_ir(5'd17, 4'd1, 4'd2, 19'h0);
        fetch("neg");
        step_chk("neg_t3", ZIN, 16'h0, 16'h0004, 4'd11);
        step_chk("neg_t4", ZLOW, 16'h0002, 16'h0, 4'd0);
        step_chk("neg_end", T0C, 16'h0, 16'h0, 4'd0);

        // mflo R6
        bus.ir = mk_ir(5'd25, 4'd6, 4'd0, 19'h0);
        fetch("mflo");
        step_chk("mflo_t3", LOOUT, 16'h0040, 16'h0, 4'd0);
        step_chk("mflo_end", T0C, 16'h0, 16'h0, 4'd0);

        // andi R9,R3,7
        bus.ir = mk_ir(5'd13, 4'd9, 4'd3, 19'h7);
        fetch("andi");
        step_chk("andi_t3", YIN, 16'h0, 16'h0008, 4'd0);
        step_chk("andi_t4", COUT | ZIN, 16'h0, 16'h0, 4'd2);
        step_chk("andi_t5", ZLOW, 16'h0200, 16'h0, 4'd0);
        step_chk("andi_end", T0C, 16'h0, 16'h0, 4'd0);

        // nop
        bus.ir = mk_ir(5'd26, 4'd0, 4'd0, 19'h0);
        fetch("nop");
        step_chk("nop_end", T0C, 16'h0, 16'h0, 4'd0);

        // ld R3,0x10(R1) with one read wait cycle
        bus.ir = mk_ir(5'd0, 4'd3, 4'd1, 19'h10);
        fetch("ld");
        step_chk("ld_t3", YIN, 16'h0, 16'h0002, 4'd0);
        step_chk("ld_t4", COUT | ZIN, 16'h0, 16'h0, 4'd0);
        step_chk("ld_t5", ZLOW | MARIN, 16'h0, 16'h0, 4'd0);
        bus.mem_ready = 1'b0;
        step_chk("ld_t6a", MRD | MDRRD, 16'h0, 16'h0, 4'd0);
        bus.mem_ready = 1'b1;
        #1 now_chk("ld_t6b", MRD | MDRRD | MDRIN, 16'h0, 16'h0, 4'd0);
        step_chk("ld_t7", MDROUT, 16'h0008, 16'h0, 4'd0);
        step_chk("ld_end", T0C, 16'h0, 16'h0, 4'd0);

        // ld again, reset while waiting in T6
        fetch("ldr");
        step_chk("ldr_t3", YIN, 16'h0, 16'h0002, 4'd0);
        step_chk("ldr_t4", COUT | ZIN, 16'h0, 16'h0, 4'd0);
        step_chk("ldr_t5", ZLOW | MARIN, 16'h0, 16'h0, 4'd0);
        bus.mem_ready = 1'b0;
        step_chk("ldr_t6a", MRD | MDRRD, 16'h0, 16'h0, 4'd0);
        step_chk("ldr_t6b", MRD | MDRRD, 16'h0, 16'h0, 4'd0);
        do_reset("ldr");

        // illegal opcode 11111: halt with illegal, frozen despite ir/mem_ready changes
        bus.ir = mk_ir(5'd31, 4'd0, 4'd0, 19'h0);
        fetch("ill");
        step_chk("ill_halt", HALTD | ILL, 16'h0, 16'h0, 4'd0);
        bus.ir        = mk_ir(5'd3, 4'd3, 4'd1, {4'd2, 15'd0});
        bus.mem_ready = 1'b0;
        step_chk("ill_frz1", HALTD | ILL, 16'h0, 16'h0, 4'd0);
        bus.mem_ready = 1'b1;
        step_chk("ill_frz2", HALTD | ILL, 16'h0, 16'h0, 4'd0);
        do_reset("ill");

        // halt: halted without illegal
        bus.ir = mk_ir(5'd27, 4'd0, 4'd0, 19'h0);
        fetch("hlt");
        step_chk("hlt_halt", HALTD, 16'h0, 16'h0, 4'd0);
        step_chk("hlt_frz", HALTD, 16'h0, 16'h0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
